deser_queue_core: RTL and testbench

Parametrised successor to the serial-to-queue datapath. It accepts a serial bit stream, assembles `DATA_W`-bit words and buffers them in a `DEPTH`-entry FIFO, which a consumer drains at a slower rate. All logic runs on one clock. The two rates come from internal clock-enable ticks, not derived clocks. The block replaces the separate deserializer, queue and glue handshake, and adds backpressure, bit-order selection, full/empty flags and a sticky overflow flag.

---
 rtl/deser_queue_core.sv | 123 ++++++++++++
 tb/tb_deser_queue_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_queue_core.sv
// Serial-to-word deserializer feeding a DEPTH-entry FIFO.
// Sample and dequeue rates come from internal clock-enable ticks.
module deser_queue_core #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int DES_DIV   = 10,
  parameter int DEQ_DIV   = 100,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       status_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int BW = $clog2(DATA_W);
  localparam int SW = (DES_DIV > 1) ? $clog2(DES_DIV) : 1;
  localparam int QW = (DEQ_DIV > 1) ? $clog2(DEQ_DIV) : 1;

  logic [SW-1:0]     des_cnt;
  logic [QW-1:0]     deq_cnt;
  logic              des_tick;
  logic              deq_tick;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nxt;
  logic [DATA_W-1:0] hold;
  logic [BW-1:0]     bcnt;
  logic              last_bit;
  logic              accept;
  logic              pop;
  logic              xfer;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign des_tick = (des_cnt == SW'(DES_DIV-1));
  assign deq_tick = (deq_cnt == QW'(DEQ_DIV-1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      des_cnt <= '0;
      deq_cnt <= '0;
    end else begin
      des_cnt <= des_tick ? '0 : des_cnt + SW'(1);
      deq_cnt <= deq_tick ? '0 : deq_cnt + QW'(1);
    end
  end

  always_comb begin
    sr_nxt = {sr[DATA_W-2:0], data_in};
    if (MSB_FIRST == 0)
      sr_nxt = {data_in, sr[DATA_W-1:1]};
  end

  assign last_bit  = (bcnt == BW'(DATA_W-1));
  assign accept    = des_tick & write_in & ~status_out;
  assign full_out  = (len_out == LW'(DEPTH));
  assign empty_out = (len_out == '0);
  assign pop       = deq_tick & dequeue_in & ~empty_out;
  // A pop frees a slot on the same edge, so a full FIFO still accepts.
  assign xfer      = status_out & (~full_out | pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr           <= '0;
      bcnt         <= '0;
      hold         <= '0;
      status_out   <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (des_tick & write_in & status_out)
        overflow_out <= 1'b1;
      if (accept) begin
        if (last_bit) begin
          hold       <= sr_nxt;
          sr         <= '0;
          bcnt       <= '0;
          status_out <= 1'b1;
        end else begin
          sr   <= sr_nxt;
          bcnt <= bcnt + BW'(1);
        end
      end else if (xfer) begin
        status_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_out <= '0;
    end else begin
      if (xfer)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({xfer, pop})
        2'b10:   len_out <= len_out + LW'(1);
        2'b01:   len_out <= len_out - LW'(1);
        default: len_out <= len_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_ptr] <= hold;
  end

  assign data_out = empty_out ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_deser_queue_core.sv
// Bench for deser_queue_core: MSB-first and LSB-first instances
// checked every cycle against a queue-based model.
module tb_deser_queue_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_in = 1'b0;
  logic write_in = 1'b0;
  logic dequeue_in = 1'b0;

  logic [7:0] m_data, l_data;
  logic [2:0] m_len, l_len;
  logic m_full, m_empty, m_stat, m_ovf;
  logic l_full, l_empty, l_stat, l_ovf;

  int n_chk = 0;
  int n_fail = 0;

  deser_queue_core #(
    .DATA_W(8), .DEPTH(4), .DES_DIV(2), .DEQ_DIV(4), .MSB_FIRST(1)
  ) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in),
    .write_in(write_in), .dequeue_in(dequeue_in),
    .data_out(m_data), .len_out(m_len), .full_out(m_full),
    .empty_out(m_empty), .status_out(m_stat), .overflow_out(m_ovf)
  );

  deser_queue_core #(
    .DATA_W(8), .DEPTH(4), .DES_DIV(2), .DEQ_DIV(4), .MSB_FIRST(0)
  ) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in),
    .write_in(write_in), .dequeue_in(dequeue_in),
    .data_out(l_data), .len_out(l_len), .full_out(l_full),
    .empty_out(l_empty), .status_out(l_stat), .overflow_out(l_ovf)
  );

  always #5 clk = ~clk;

  // Model state: edges since reset, collected bits, hold word, queues.
  int       cyc = 0;
  bit       bits[$];
  bit       hv = 0;
  bit [7:0] hm, hl;
  bit [7:0] qm[$];
  bit [7:0] ql[$];
  bit       ovf = 0;
  bit       m_lst = 0;
  bit       m_lpop = 0;
  bit       chk_en = 0;

  always @(posedge clk) begin
    bit st, dt, pop, xf, acc;
    if (!reset) begin
      cyc = 0;
      bits.delete();
      hv = 0;
      qm.delete();
      ql.delete();
      ovf = 0;
      m_lst = 0;
      m_lpop = 0;
      chk_en = 1;
    end else begin
      cyc++;
      st  = (cyc % 2) == 0;
      dt  = (cyc % 4) == 0;
      pop = dt && dequeue_in && (qm.size() > 0);
      xf  = hv && ((qm.size() < 4) || pop);
      acc = st && write_in && !hv;
      if (st && write_in && hv) ovf = 1;
      if (pop) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (xf) begin
        qm.push_back(hm);
        ql.push_back(hl);
        hv = 0;
      end
      if (acc) begin
        bits.push_back(data_in);
        if (bits.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            hm[7-i] = bits[i];
            hl[i]   = bits[i];
          end
          hv = 1;
          bits.delete();
        end
      end
      m_lst  = st;
      m_lpop = pop;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] em, el;
    #1;
    if (chk_en) begin
      em = (qm.size() > 0) ? qm[0] : 8'h00;
      el = (ql.size() > 0) ? ql[0] : 8'h00;
      chk("m_data", 32'(m_data), 32'(em));
      chk("l_data", 32'(l_data), 32'(el));
      chk("m_len", 32'(m_len), qm.size());
      chk("l_len", 32'(l_len), ql.size());
      chk("m_full", 32'(m_full), 32'(qm.size() == 4));
      chk("l_full", 32'(l_full), 32'(ql.size() == 4));
      chk("m_empty", 32'(m_empty), 32'(qm.size() == 0));
      chk("l_empty", 32'(l_empty), 32'(ql.size() == 0));
      chk("m_status", 32'(m_stat), 32'(hv));
      chk("l_status", 32'(l_stat), 32'(hv));
      chk("m_ovf", 32'(m_ovf), 32'(ovf));
      chk("l_ovf", 32'(l_ovf), 32'(ovf));
    end
  end

  task automatic send_bit(input logic b);
    int n;
    @(negedge clk);
    data_in  = b;
    write_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_lst && n < 8);
    chk("bit_tick_seen", 32'(m_lst), 1);
    write_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--)
      send_bit(w[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    dequeue_in = 1'b1;
    wait_cycles(12);
    dequeue_in = 1'b0;
    chk("drain_empty", 32'(m_empty), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    write_in = 1'b0;
    dequeue_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] exp_drain [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h00};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst_data", 32'(m_data), 0);
    chk("rst_len", 32'(m_len), 0);
    chk("rst_empty", 32'(m_empty), 1);
    chk("rst_full", 32'(m_full), 0);
    chk("rst_status", 32'(m_stat), 0);
    chk("rst_ovf", 32'(m_ovf), 0);
    wait_cycles(50);
    chk("idle_len", 32'(m_len), 0);
    chk("idle_empty", 32'(l_empty), 1);

    send_word(8'hA5);
    wait_cycles(4);
    chk("single_msb", 32'(m_data), 32'h A5);
    chk("single_lsb", 32'(l_data), 32'h A5);
    chk("single_len", 32'(m_len), 1);
    drain();

    send_word(8'h01);
    wait_cycles(4);
    chk("order_msb", 32'(m_data), 32'h01);
    chk("order_lsb", 32'(l_data), 32'h80);
    drain();

    for (int i = 1; i <= 5; i++)
      send_word(8'(8'h11 * i));
    wait_cycles(4);
    chk("fill_full", 32'(m_full), 1);
    chk("fill_len", 32'(m_len), 4);
    chk("fill_status", 32'(m_stat), 1);
    chk("fill_head", 32'(m_data), 32'h11);
    chk("fill_ovf0", 32'(m_ovf), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cycles(1);
    chk("fill_ovf1", 32'(m_ovf), 1);

    @(negedge clk);
    dequeue_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_lpop && n < 20);
      chk("drain_pop_seen", 32'(m_lpop), 1);
      chk("drain_data", 32'(m_data), 32'(exp_drain[k]));
      if (k == 0) begin
        chk("drain_len_kept", 32'(m_len), 4);
        chk("drain_xfer", 32'(m_stat), 0);
      end
    end
    wait_cycles(20);
    chk("drain_len0", 32'(m_len), 0);
    chk("drain_data0", 32'(m_data), 0);
    dequeue_in = 1'b0;

    do_reset();
    chk("ovf_cleared", 32'(m_ovf), 0);

    dequeue_in = 1'b1;
    for (int i = 0; i < 10; i++)
      send_word(8'(8'h0F + i * 23));
    wait_cycles(30);
    chk("wrap_ovf", 32'(m_ovf), 0);
    chk("wrap_len", 32'(m_len), 0);
    chk("wrap_status", 32'(m_stat), 0);
    dequeue_in = 1'b0;

    send_word(8'h3C);
    send_word(8'hC3);
    wait_cycles(4);
    chk("mid_len2", 32'(m_len), 2);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    do_reset();
    chk("mid_len0", 32'(m_len), 0);
    send_word(8'h6B);
    wait_cycles(4);
    chk("fresh_msb", 32'(m_data), 32'h6B);
    chk("fresh_lsb", 32'(l_data), 32'hD6);
    chk("fresh_len", 32'(m_len), 1);
    wait_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
